alu_pipe: RTL and testbench

Parametrised, registered ALU with valid/ready handshakes on its input and output, a sticky carry flag for multi-word arithmetic, and a full flag set (carry, zero, negative, overflow). It is the datapath execution unit that sits between an operand/issue stage and a result consumer. Most ops complete in one cycle. MUL is a sequential shift-add operation that takes WIDTH cycles. The output register holds its result stable under backpressure.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_mul_seq.sv | 53 +++++
 rtl/alu_pipe.sv | 153 +++++++++++++++
 tb/tb_alu_pipe.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcodes, result flags and control states.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_ADC = 4'h2,
    OP_SBC = 4'h3,
    OP_AND = 4'h4,
    OP_OR  = 4'h5,
    OP_XOR = 4'h6,
    OP_NOT = 4'h7,
    OP_SHL = 4'h8,
    OP_SHR = 4'h9,
    OP_ASR = 4'hA,
    OP_ROL = 4'hB,
    OP_MUL = 4'hC
  } alu_op_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic neg;
    logic ovf;
  } alu_flags_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier: one partial product per cycle, WIDTH steps.
// done/prod_* reflect the final step combinationally so the caller loads on that edge.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic             prod_hi_nz
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic             running;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [PW-1:0]    acc_nxt;

  assign acc_nxt    = b_sh[0] ? (acc + a_sh) : acc;
  assign done       = running && (cnt == CNT_W'(WIDTH - 1));
  assign prod_lo    = acc_nxt[WIDTH-1:0];
  assign prod_hi_nz = |acc_nxt[PW-1:WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      acc     <= '0;
      a_sh    <= PW'(a);
      b_sh    <= b;
    end else if (running) begin
      acc  <= acc_nxt;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt + CNT_W'(1);
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides, sticky carry for multi-word
// arithmetic, and a WIDTH-cycle sequential multiplier.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf,
  output logic             busy
);

  localparam int unsigned XW = WIDTH + 1;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             ovf;
  } calc_t;

  alu_state_e       state;
  alu_flags_t       flags_q;
  logic             c_q;
  logic             accept;
  logic             op_is_mul;
  logic             load;
  logic             mul_done;
  logic [WIDTH-1:0] mul_lo;
  logic             mul_hi_nz;
  calc_t            calc;
  logic [WIDTH-1:0] ld_res;
  logic             ld_carry;
  logic             ld_ovf;

  // Single-cycle ops; MUL and illegal opcodes fall to the all-zero default.
  function automatic calc_t alu_calc(input alu_op_e op, input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b, input logic cq);
    calc_t     r;
    logic [WIDTH:0] ext;
    r   = '0;
    ext = '0;
    case (op)
      OP_ADD, OP_ADC: begin
        ext = {1'b0, a} + {1'b0, b} + ((op == OP_ADC) ? XW'(cq) : XW'(0));
        r.result = ext[WIDTH-1:0];
        r.carry  = ext[WIDTH];
        r.ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_SBC: begin
        ext = {1'b0, a} - {1'b0, b} - ((op == OP_SBC) ? XW'(cq) : XW'(0));
        r.result = ext[WIDTH-1:0];
        r.carry  = ext[WIDTH];
        r.ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: r.result = a & b;
      OP_OR:  r.result = a | b;
      OP_XOR: r.result = a ^ b;
      OP_NOT: r.result = ~a;
      OP_SHL: begin
        r.result = {a[WIDTH-2:0], 1'b0};
        r.carry  = a[WIDTH-1];
      end
      OP_SHR: begin
        r.result = {1'b0, a[WIDTH-1:1]};
        r.carry  = a[0];
      end
      OP_ASR: begin
        r.result = {a[WIDTH-1], a[WIDTH-1:1]};
        r.carry  = a[0];
      end
      OP_ROL: begin
        r.result = {a[WIDTH-2:0], a[WIDTH-1]};
        r.carry  = a[WIDTH-1];
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    calc = alu_calc(alu_op_e'(in_op), in_a, in_b, c_q);
  end

  assign in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign op_is_mul = (in_op == OP_MUL);
  assign load      = (accept && !op_is_mul) || mul_done;
  assign ld_res    = mul_done ? mul_lo : calc.result;
  assign ld_carry  = mul_done ? mul_hi_nz : calc.carry;
  assign ld_ovf    = mul_done ? 1'b0 : calc.ovf;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk        (clk),
    .rst        (rst),
    .start      (accept && op_is_mul),
    .a          (in_a),
    .b          (in_b),
    .done       (mul_done),
    .prod_lo    (mul_lo),
    .prod_hi_nz (mul_hi_nz)
  );

  // Control state and output register; a load wins over a plain delivery.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      flags_q    <= '0;
      c_q        <= 1'b0;
    end else begin
      if (state == ST_IDLE) begin
        if (accept && op_is_mul) begin
          state <= ST_MUL;
          busy  <= 1'b1;
        end
      end else if (mul_done) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end
      if (load) begin
        out_valid     <= 1'b1;
        out_result    <= ld_res;
        flags_q.carry <= ld_carry;
        flags_q.zero  <= (ld_res == '0);
        flags_q.neg   <= ld_res[WIDTH-1];
        flags_q.ovf   <= ld_ovf;
        c_q           <= ld_carry;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign out_carry = flags_q.carry;
  assign out_zero  = flags_q.zero;
  assign out_neg   = flags_q.neg;
  assign out_ovf   = flags_q.ovf;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe (WIDTH=8) with hand-computed expectations.
module tb_alu_pipe;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [3:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic       out_carry;
  logic       out_zero;
  logic       out_neg;
  logic       out_ovf;
  logic       busy;

  int checks = 0;
  int errors = 0;

  alu_pipe #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .out_ovf    (out_ovf),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Flags packed as {carry, zero, neg, ovf}
  function automatic logic [3:0] flags_now();
    return {out_carry, out_zero, out_neg, out_ovf};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] er, input logic [3:0] ef);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    #0;
    check({tag, ":rdy"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check({tag, ":vld"}, 32'(out_valid), 32'd1);
    check({tag, ":res"}, 32'(out_result), 32'(er));
    check({tag, ":flg"}, 32'(flags_now()), 32'(ef));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 4'h0;
    in_a      = 8'h00;
    in_b      = 8'h00;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res", 32'(out_result), 32'd0);
    check("rst_flg", 32'(flags_now()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("idle_rdy", 32'(in_ready), 32'd1);

    // Back-to-back single-cycle ops, one result per cycle
    out_ready = 1'b1;
    do_op("add_ff01", OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b1100);
    do_op("adc_0000", OP_ADC, 8'h00, 8'h00, 8'h01, 4'b0000);
    do_op("sub_8001", OP_SUB, 8'h80, 8'h01, 8'h7F, 4'b0001);
    do_op("sub_0102", OP_SUB, 8'h01, 8'h02, 8'hFF, 4'b1010);
    do_op("sbc_0502", OP_SBC, 8'h05, 8'h02, 8'h02, 4'b0000);
    do_op("and",      OP_AND, 8'hF0, 8'h3C, 8'h30, 4'b0000);
    do_op("or",       OP_OR,  8'h0F, 8'hF0, 8'hFF, 4'b0010);
    do_op("xor",      OP_XOR, 8'hAA, 8'hAA, 8'h00, 4'b0100);
    do_op("not",      OP_NOT, 8'h55, 8'hFF, 8'hAA, 4'b0010);
    do_op("shl",      OP_SHL, 8'h81, 8'h00, 8'h02, 4'b1000);
    do_op("shr",      OP_SHR, 8'h81, 8'h00, 8'h40, 4'b1000);
    do_op("asr",      OP_ASR, 8'h81, 8'h00, 8'hC0, 4'b1010);
    do_op("rol",      OP_ROL, 8'h81, 8'h00, 8'h03, 4'b1000);
    do_op("illegal",  4'hD,   8'hFF, 8'hFF, 8'h00, 4'b0100);
    do_op("adc_clr",  OP_ADC, 8'h00, 8'h00, 8'h00, 4'b0100);
    do_op("add_7f01", OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b0011);
    tick();
    check("drain_vld", 32'(out_valid), 32'd0);

    // MUL 0x0F*0x11: result exactly 8 cycles after accept
    in_valid = 1'b1;
    in_op    = OP_MUL;
    in_a     = 8'h0F;
    in_b     = 8'h11;
    #0;
    check("mul1_rdy", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("mul1_busy", 32'(busy), 32'd1);
      check("mul1_nrdy", 32'(in_ready), 32'd0);
      check("mul1_nvld", 32'(out_valid), 32'd0);
      tick();
    end
    check("mul1_vld", 32'(out_valid), 32'd1);
    check("mul1_res", 32'(out_result), 32'hFF);
    check("mul1_flg", 32'(flags_now()), 32'b0010);
    check("mul1_idle", 32'(busy), 32'd0);

    // MUL 0x10*0x10 accepted while the first result is delivered
    in_valid = 1'b1;
    in_op    = OP_MUL;
    in_a     = 8'h10;
    in_b     = 8'h10;
    #0;
    check("mul2_rdy", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("mul2_dlv", 32'(out_valid), 32'd0);
    for (int i = 0; i < 8; i++) tick();
    check("mul2_vld", 32'(out_valid), 32'd1);
    check("mul2_res", 32'(out_result), 32'h00);
    check("mul2_flg", 32'(flags_now()), 32'b1100);
    do_op("adc_mulc", OP_ADC, 8'h00, 8'h00, 8'h01, 4'b0000);
    tick();
    check("drain2_vld", 32'(out_valid), 32'd0);

    // Backpressure: pending result held, second op waits then loads on release
    out_ready = 1'b0;
    do_op("bp_add", OP_ADD, 8'h01, 8'h02, 8'h03, 4'b0000);
    in_valid = 1'b1;
    in_op    = OP_SUB;
    in_a     = 8'h09;
    in_b     = 8'h04;
    #0;
    check("bp_nrdy", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_vld", 32'(out_valid), 32'd1);
      check("bp_hold_res", 32'(out_result), 32'h03);
      check("bp_hold_rdy", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #0;
    check("bp_rdy", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp2_vld", 32'(out_valid), 32'd1);
    check("bp2_res", 32'(out_result), 32'h05);
    check("bp2_flg", 32'(flags_now()), 32'b0000);
    tick();
    check("bp_nodup", 32'(out_valid), 32'd0);

    // Reset in the middle of a MUL
    do_op("pre_rst_add", OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b1100);
    tick();
    in_valid = 1'b1;
    in_op    = OP_MUL;
    in_a     = 8'h03;
    in_b     = 8'h05;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("mr_busy_pre", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mr_vld", 32'(out_valid), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_res", 32'(out_result), 32'd0);
    check("mr_flg", 32'(flags_now()), 32'd0);
    tick();
    @(negedge clk);
    rst = 1'b0;
    #0;
    check("mr_rdy", 32'(in_ready), 32'd1);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("mr_nostale", 32'({out_valid, busy}), 32'd0);
    end
    do_op("mr_adc", OP_ADC, 8'h00, 8'h00, 8'h00, 4'b0100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
